// File: rtl/wdt_multi_ch_if.sv
// Register port bundle for the multi-channel watchdog.
// Master drives strobes/address/data, slave returns read data.
interface wdt_multi_ch_if;
  logic        reg_wen;
  logic        reg_ren;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;

  modport master (
    output reg_wen, reg_ren, reg_addr, reg_wdata,
    input  reg_rdata, reg_rvalid
  );

  modport slave (
    input  reg_wen, reg_ren, reg_addr, reg_wdata,
    output reg_rdata, reg_rvalid
  );
endinterface

// File: rtl/wdt_multi_ch.sv
// NUM_CH independent watchdog channels on one clock and prescaler.
// Optional pre-warning stage enabled by defining WDT_PREWARN_EN.
module wdt_multi_ch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int DIV    = 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  wdt_multi_ch_if.slave     bus,
  output logic [NUM_CH-1:0] wto,
  output logic              interrupt_t
`ifdef WDT_PREWARN_EN
  ,
  output logic [NUM_CH-1:0] warn
`endif
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_TMO
  } state_t;

  state_t           r_st    [NUM_CH];
  logic [CNT_W-1:0] r_cnt   [NUM_CH];
  logic [CNT_W-1:0] r_tocnt [NUM_CH];
  logic [NUM_CH-1:0] r_wto;
  logic [PW-1:0]    r_presc;
  logic [31:0]      r_rdata;
  logic             r_rvalid;

  logic [3:0]        w_ch;
  logic              w_o_ctrl;
  logic              w_o_kick;
  logic              w_o_cnt;
  logic              w_o_stat;
  logic              w_kdata;
  logic              w_tick;
  logic [NUM_CH-1:0] w_act;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_wcnt;
  logic [NUM_CH-1:0] w_dis;
  logic [NUM_CH-1:0] w_en;
  logic [NUM_CH-1:0] w_kick;
  logic [NUM_CH-1:0] w_rld;
  logic [NUM_CH-1:0] w_ovr;
  logic [NUM_CH-1:0] w_step;
  logic [NUM_CH-1:0] w_hold;
  logic [NUM_CH-1:0] w_warn_b;
  logic [31:0]       w_rd;

  assign w_ch     = bus.reg_addr[7:4];
  assign w_o_ctrl = bus.reg_addr[3:0] == 4'h0;
  assign w_o_kick = bus.reg_addr[3:0] == 4'h4;
  assign w_o_cnt  = bus.reg_addr[3:0] == 4'h8;
  assign w_o_stat = bus.reg_addr[3:0] == 4'hC;
  assign w_kdata  = |bus.reg_wdata;
  assign w_tick   = (|w_act) && (r_presc == PW'(DIV - 1));

  // Per-channel event decode; write events are mutually exclusive
  always_comb begin
    w_act  = '0;
    w_sel  = '0;
    w_wcnt = '0;
    w_dis  = '0;
    w_en   = '0;
    w_kick = '0;
    w_rld  = '0;
    w_ovr  = '0;
    w_step = '0;
    w_hold = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_act[i]  = r_st[i] != S_IDLE;
      w_sel[i]  = bus.reg_wen && (w_ch == 4'(i));
      w_wcnt[i] = w_sel[i] && w_o_cnt;
      w_dis[i]  = w_sel[i] && w_o_ctrl && !bus.reg_wdata[0];
      w_en[i]   = w_sel[i] && w_o_ctrl && bus.reg_wdata[0]
                  && (r_st[i] == S_IDLE);
      w_kick[i] = w_sel[i] && w_o_kick && w_kdata && w_act[i];
      w_rld[i]  = w_wcnt[i] && (r_st[i] == S_COUNT);
      w_ovr[i]  = w_dis[i] | w_en[i] | w_kick[i] | w_rld[i];
      w_step[i] = !w_ovr[i] && w_tick && (r_st[i] == S_COUNT);
      w_hold[i] = !w_ovr[i] && (r_st[i] == S_TMO);
    end
  end

  // Prescaler free-runs only while some channel is enabled
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_presc <= '0;
    end else if (!(|w_act) || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Channel FSMs: disable > kick > WTOCNT reload > terminal tick
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_st[i]    <= S_IDLE;
        r_cnt[i]   <= '0;
        r_tocnt[i] <= '0;
      end
      r_wto <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wcnt[i])
          r_tocnt[i] <= bus.reg_wdata[CNT_W-1:0];
        unique case (1'b1)
          w_dis[i]: begin
            r_st[i]  <= S_IDLE;
            r_cnt[i] <= '0;
            r_wto[i] <= 1'b0;
          end
          w_en[i]: begin
            r_st[i]  <= S_COUNT;
            r_cnt[i] <= '0;
          end
          w_kick[i]: begin
            r_st[i]  <= S_COUNT;
            r_cnt[i] <= '0;
            r_wto[i] <= 1'b0;
          end
          w_rld[i]: begin
            r_cnt[i] <= '0;
          end
          w_step[i]: begin
            if (r_cnt[i] == r_tocnt[i])
              r_st[i] <= S_TMO;
            else
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
          w_hold[i]: begin
            r_wto[i] <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef WDT_PREWARN_EN
  logic [NUM_CH-1:0] r_warn;
  logic [NUM_CH-1:0] w_whit;

  // Warn point: half of WTOCNT, or the terminal tick for tiny limits
  always_comb begin
    w_whit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_tocnt[i] < CNT_W'(2))
        w_whit[i] = r_cnt[i] == r_tocnt[i];
      else
        w_whit[i] = r_cnt[i] == (r_tocnt[i] >> 1);
    end
  end

  // Sticky warn flag, cleared by kick/disable/enable
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_warn <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_dis[i] | w_en[i] | w_kick[i])
          r_warn[i] <= 1'b0;
        else if (w_step[i] && w_whit[i])
          r_warn[i] <= 1'b1;
      end
    end
  end

  assign w_warn_b = r_warn;
  assign warn     = r_warn;
`else
  assign w_warn_b = '0;
`endif

  // Read mux over pre-write register state
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == 4'(i)) begin
        unique case (1'b1)
          w_o_ctrl: w_rd = {31'b0, w_act[i]};
          w_o_cnt:  w_rd = 32'(r_tocnt[i]);
          w_o_stat: w_rd = {30'b0, w_warn_b[i], r_wto[i]};
          default:  w_rd = '0;
        endcase
      end
    end
  end

  // Read response: one-cycle valid, data held between reads
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus.reg_ren;
      if (bus.reg_ren)
        r_rdata <= w_rd;
    end
  end

  assign bus.reg_rdata  = r_rdata;
  assign bus.reg_rvalid = r_rvalid;
  assign wto            = r_wto;
  assign interrupt_t    = |r_wto;

endmodule
